// File: rtl/ov_pkg.sv
// Shared definitions for the OV sensor init sequencer.
// Holds the FSM state encoding, table-entry markers, IIC status bit positions
// and a helper that classifies a table entry.
package ov_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_ISSUE   = 4'd3,
    S_WAIT_HI = 4'd4,
    S_WAIT_LO = 4'd5,
    S_DELAY   = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    E_WRITE,
    E_DELAY,
    E_END
  } entry_t;

  localparam logic [15:0] END_MARK  = 16'hFFFF;
  localparam logic [7:0]  DLY_TAG   = 8'hFE;
  localparam logic [7:0]  ACT_WRITE = 8'h01;
  localparam int          ST_BUSY   = 0;
  localparam int          ST_NACK   = 1;
  localparam int          US_PER_MS = 1000;

  // End marker wins over the delay tag (FFFF also starts with FE? no, FF),
  // so test it first anyway to keep the ordering obvious.
  function automatic entry_t decode_entry(input logic [15:0] e);
    if (e == END_MARK)          return E_END;
    else if (e[15:8] == DLY_TAG) return E_DELAY;
    else                         return E_WRITE;
  endfunction

endpackage

// File: rtl/ov_us_timer.sv
// Loadable down-counter paced by a 1 us pulse.
// In us mode each pluse_us decrements the count; in ms mode a prescaler
// swallows US_PER_MS pulses per decrement. done is high while the count is 0.
// Ports:
//   clk_sys, rst_n  clock / async active-low reset
//   pluse_us        one-cycle pulse every 1 us
//   load            load load_val and ms_mode, restart prescaler
//   ms_mode         1: count milliseconds, 0: count microseconds
//   load_val        initial count
//   done            count has reached zero
module ov_us_timer
  import ov_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         pluse_us,
  input  logic         load,
  input  logic         ms_mode,
  input  logic [W-1:0] load_val,
  output logic         done
);

  localparam logic [9:0] SUB_LAST = 10'(US_PER_MS - 1);

  logic [W-1:0] cnt;
  logic [9:0]   sub;
  logic         ms;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sub <= '0;
      ms  <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      sub <= '0;
      ms  <= ms_mode;
    end else if (pluse_us && cnt != '0) begin
      if (!ms) begin
        cnt <= cnt - 1'b1;
      end else if (sub == SUB_LAST) begin
        sub <= '0;
        cnt <= cnt - 1'b1;
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ov_cfg_seq.sv
// Sensor register-init sequencer. Walks a table ROM from entry 0, issuing one
// IIC write per entry through the IIC master register interface, honouring
// ms delay entries, retrying NACKed writes and bounding each transaction.
// Ports:
//   clk_sys, rst_n        clock / async active-low reset
//   pluse_us              1 us tick
//   start                 begin a sequence (ignored while one runs)
//   tab_addr / tab_data   table ROM, data valid one cycle after address
//   cfg_iic_devid/addr/wdata, act_iic_write  IIC master request
//   stu_iic_status        IIC master status {.., nack, busy}
//   seq_busy/done/err, err_idx  sequence status
module ov_cfg_seq
  import ov_pkg::*;
#(
  parameter logic [7:0] DEVID      = 8'h42,
  parameter int         TAB_AW     = 8,
  parameter int         MAX_RETRY  = 3,
  parameter int         TIMEOUT_US = 2000
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              pluse_us,
  input  logic              start,
  output logic [TAB_AW-1:0] tab_addr,
  input  logic [15:0]       tab_data,
  output logic [7:0]        cfg_iic_devid,
  output logic [7:0]        cfg_iic_addr,
  output logic [7:0]        cfg_iic_wdata,
  output logic [7:0]        act_iic_write,
  input  logic [7:0]        stu_iic_status,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [TAB_AW-1:0] err_idx
);

  // Timer must hold both the us timeout and an 8-bit ms delay count.
  localparam int TW = ($clog2(TIMEOUT_US + 1) > 8) ? $clog2(TIMEOUT_US + 1) : 8;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TAB_AW-1:0] LAST_IDX = '1;

  state_t          state, nxt;
  logic [RW-1:0]   retry;
  logic            busy_in, nack_in;
  logic            tmr_ld, tmr_ms, tmr_done;
  logic [TW-1:0]   tmr_val;
  logic            clr, adv, latch, inc_retry, clr_retry;
  logic [5:0]      unused_status;

  assign busy_in       = stu_iic_status[ST_BUSY];
  assign nack_in       = stu_iic_status[ST_NACK];
  assign unused_status = stu_iic_status[7:2];
  assign cfg_iic_devid = DEVID;

  ov_us_timer #(.W(TW)) u_tmr (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .pluse_us (pluse_us),
    .load     (tmr_ld),
    .ms_mode  (tmr_ms),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    clr       = 1'b0;
    adv       = 1'b0;
    latch     = 1'b0;
    inc_retry = 1'b0;
    clr_retry = 1'b0;
    tmr_ld    = 1'b0;
    tmr_ms    = 1'b0;
    tmr_val   = '0;
    case (state)
      S_IDLE: if (start) begin
        nxt = S_FETCH;
        clr = 1'b1;
      end
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (decode_entry(tab_data))
          E_END:   nxt = S_DONE;
          E_DELAY: begin
            nxt     = S_DELAY;
            tmr_ld  = 1'b1;
            tmr_ms  = 1'b1;
            tmr_val = TW'(tab_data[7:0]);
          end
          default: begin
            nxt   = S_ISSUE;
            latch = 1'b1;
          end
        endcase
      end
      S_ISSUE: begin
        nxt     = S_WAIT_HI;
        tmr_ld  = 1'b1;
        tmr_val = TW'(TIMEOUT_US);
      end
      S_WAIT_HI: begin
        if (busy_in)       nxt = S_WAIT_LO;
        else if (tmr_done) nxt = S_ERR;
      end
      S_WAIT_LO: begin
        if (!busy_in) begin
          if (!nack_in) begin
            clr_retry = 1'b1;
            // The table has no wrap: running off the last index is an error.
            if (tab_addr == LAST_IDX) nxt = S_ERR;
            else begin
              nxt = S_FETCH;
              adv = 1'b1;
            end
          end else if (retry < RW'(MAX_RETRY)) begin
            nxt       = S_ISSUE;
            inc_retry = 1'b1;
          end else begin
            nxt = S_ERR;
          end
        end else if (tmr_done) begin
          nxt = S_ERR;
        end
      end
      S_DELAY: if (tmr_done) begin
        if (tab_addr == LAST_IDX) nxt = S_ERR;
        else begin
          nxt = S_FETCH;
          adv = 1'b1;
        end
      end
      S_DONE:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      tab_addr      <= '0;
      cfg_iic_addr  <= '0;
      cfg_iic_wdata <= '0;
      act_iic_write <= '0;
      retry         <= '0;
      seq_busy      <= 1'b0;
      seq_done      <= 1'b0;
      seq_err       <= 1'b0;
      err_idx       <= '0;
    end else begin
      // Registered strobe: high exactly while the FSM sits in ISSUE.
      act_iic_write <= (nxt == S_ISSUE) ? ACT_WRITE : 8'h00;
      if (clr) begin
        tab_addr <= '0;
        seq_done <= 1'b0;
        seq_err  <= 1'b0;
        seq_busy <= 1'b1;
      end
      if (adv) tab_addr <= tab_addr + 1'b1;
      // addr/wdata only change in DECODE, so they hold through every retry.
      if (latch) begin
        cfg_iic_addr  <= tab_data[15:8];
        cfg_iic_wdata <= tab_data[7:0];
      end
      if (clr || clr_retry) retry <= '0;
      else if (inc_retry)   retry <= retry + 1'b1;
      if (state == S_DONE) begin
        seq_done <= 1'b1;
        seq_busy <= 1'b0;
      end
      if (state == S_ERR) begin
        seq_err  <= 1'b1;
        err_idx  <= tab_addr;
        seq_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ov_cfg_seq.sv
// Directed bench for ov_cfg_seq: table ROM model, IIC slave model with
// programmable NACK / stall behaviour, and a strobe scoreboard.
module tb_ov_cfg_seq;

  localparam int TAB_AW     = 8;
  localparam int MAX_RETRY  = 3;
  localparam int TIMEOUT_US = 2000;
  localparam int BUSY_US    = 50;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        pluse_us = 1'b0;
  logic        start   = 1'b0;
  logic [7:0]  tab_addr;
  logic [15:0] tab_data;
  logic [7:0]  cfg_iic_devid, cfg_iic_addr, cfg_iic_wdata, act_iic_write;
  logic [7:0]  stu_iic_status;
  logic        seq_busy, seq_done, seq_err;
  logic [7:0]  err_idx;

  ov_cfg_seq #(
    .DEVID(8'h42), .TAB_AW(TAB_AW), .MAX_RETRY(MAX_RETRY), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .pluse_us       (pluse_us),
    .start          (start),
    .tab_addr       (tab_addr),
    .tab_data       (tab_data),
    .cfg_iic_devid  (cfg_iic_devid),
    .cfg_iic_addr   (cfg_iic_addr),
    .cfg_iic_wdata  (cfg_iic_wdata),
    .act_iic_write  (act_iic_write),
    .stu_iic_status (stu_iic_status),
    .seq_busy       (seq_busy),
    .seq_done       (seq_done),
    .seq_err        (seq_err),
    .err_idx        (err_idx)
  );

  always #5 clk_sys = ~clk_sys;

  // Table ROM with one cycle of read latency.
  logic [15:0] rom [0:255];
  always @(posedge clk_sys) tab_data <= rom[tab_addr];

  // Slave / pulse model state (written only by the negedge process).
  logic        busy = 1'b0, nack = 1'b0, nack_pend = 1'b0;
  int          busy_cnt = 0, pdiv = 0, pul_total = 0, stb_pul = 0, bad_hi = 0;
  logic [15:0] obs_q [$];
  // Scenario controls (written only by the initial block).
  int          base = 0, nlo = 0, nhi = 0, nb_from = 1000;

  logic [15:0] exp_q [$];
  int          rd = 0, p0_start = 0;
  int          checks = 0, errors = 0;

  assign stu_iic_status = {6'b0, nack, busy};

  always @(negedge clk_sys) begin
    int idx;
    if (act_iic_write[7:1] != 7'd0) bad_hi++;
    if (busy && pluse_us) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        busy = 1'b0;
        nack = nack_pend;
      end
    end
    if (act_iic_write[0]) begin
      idx = obs_q.size() - base;
      obs_q.push_back({cfg_iic_addr, cfg_iic_wdata});
      stb_pul = pul_total;
      nack = 1'b0;
      if (idx < nb_from) begin
        busy      = 1'b1;
        busy_cnt  = BUSY_US;
        nack_pend = (idx >= nlo) && (idx < nhi);
      end
    end
    pdiv     = (pdiv == 3) ? 0 : pdiv + 1;
    pluse_us = (pdiv == 0);
    if (pluse_us) pul_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input int lo, input int hi, input int nbf);
    base    = obs_q.size();
    rd      = base;
    nlo     = lo;
    nhi     = hi;
    nb_from = nbf;
  endtask

  // lat counts negedges after start is raised until the strobe is seen;
  // 3 means the strobe occupies the 4th cycle counting the start cycle.
  task automatic do_start(output int lat);
    @(negedge clk_sys); start = 1'b1;
    @(posedge clk_sys); p0_start = pul_total;
    @(negedge clk_sys); start = 1'b0;
    lat = 1;
    while (!act_iic_write[0] && lat < 10) begin
      @(negedge clk_sys);
      lat++;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (seq_busy && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    chk({tag, "_idle"}, seq_busy, 1'b0);
  endtask

  task automatic sb_check(input string tag);
    logic [15:0] e, o;
    chk({tag, "_nstb"}, obs_q.size() - base, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (rd < obs_q.size()) ? obs_q[rd] : 16'h0000;
      rd++;
      chk({tag, "_stb"}, o, e);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_taddr"}, tab_addr, 0);
    chk({tag, "_devid"}, cfg_iic_devid, 8'h42);
    chk({tag, "_addr"},  cfg_iic_addr, 0);
    chk({tag, "_wdata"}, cfg_iic_wdata, 0);
    chk({tag, "_act"},   act_iic_write, 0);
    chk({tag, "_busy"},  seq_busy, 0);
    chk({tag, "_done"},  seq_done, 0);
    chk({tag, "_err"},   seq_err, 0);
    chk({tag, "_eidx"},  err_idx, 0);
  endtask

  initial begin
    int lat, d, n;
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    repeat (4) @(negedge clk_sys);
    chk_reset("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // 1: two acked writes, start-to-strobe latency
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
    setup(0, 0, 1000);
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
    do_start(lat);
    chk("t1_lat", lat, 3);
    chk("t1_act", act_iic_write, 8'h01);
    wait_idle("t1", 20000);
    sb_check("t1");
    chk("t1_done", seq_done, 1);
    chk("t1_err", seq_err, 0);

    // 2: 5 ms delay then a write
    rom[0] = 16'hFE05; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
    setup(0, 0, 1000);
    exp_q.push_back(16'h3A04);
    do_start(lat);
    wait_idle("t2", 40000);
    d = stb_pul - p0_start;
    chk("t2_dly_min", d >= 5000, 1);
    chk("t2_dly_max", d <= 5005, 1);
    sb_check("t2");
    chk("t2_done", seq_done, 1);

    // 3: entry 1 NACKed twice then acked
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
    setup(1, 3, 1000);
    exp_q.push_back(16'h1280);
    repeat (3) exp_q.push_back(16'h1101);
    do_start(lat);
    wait_idle("t3", 20000);
    sb_check("t3");
    chk("t3_done", seq_done, 1);
    chk("t3_err", seq_err, 0);

    // 4: entry 0 always NACKed -> MAX_RETRY+1 strobes then error
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    setup(0, 1000, 1000);
    repeat (MAX_RETRY + 1) exp_q.push_back(16'h1280);
    do_start(lat);
    wait_idle("t4", 20000);
    sb_check("t4");
    chk("t4_err", seq_err, 1);
    chk("t4_eidx", err_idx, 0);
    chk("t4_done", seq_done, 0);

    // 5: slave never raises busy on entry 1; extra start mid-sequence ignored
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
    setup(0, 0, 1);
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
    do_start(lat);
    n = 0;
    while (obs_q.size() - base < 2 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (20) @(negedge clk_sys);
    chk("t5_busy_mid", seq_busy, 1);
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    wait_idle("t5", 20000);
    @(posedge clk_sys);
    d = pul_total - stb_pul;
    chk("t5_to_min", d >= TIMEOUT_US, 1);
    chk("t5_to_max", d <= TIMEOUT_US + 3, 1);
    sb_check("t5");
    chk("t5_err", seq_err, 1);
    chk("t5_eidx", err_idx, 1);

    // 6: reset while waiting for busy to fall, then a clean rerun
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    setup(0, 0, 1000);
    do_start(lat);
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b0;
    @(negedge clk_sys);
    chk_reset("t6_rst");
    rst_n = 1'b1;
    n = 0;
    while (stu_iic_status[0] && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (4) @(negedge clk_sys);
    setup(0, 0, 1000);
    exp_q.push_back(16'h1280);
    do_start(lat);
    chk("t6_lat", lat, 3);
    wait_idle("t6", 20000);
    sb_check("t6");
    chk("t6_done", seq_done, 1);

    // 7: table of zero delays with no end marker -> error at last index
    for (int i = 0; i < 256; i++) rom[i] = 16'hFE00;
    setup(0, 0, 1000);
    do_start(lat);
    wait_idle("t7", 5000);
    sb_check("t7");
    chk("t7_err", seq_err, 1);
    chk("t7_eidx", err_idx, 8'hFF);
    chk("t7_done", seq_done, 0);

    chk("act_hi_bits", bad_hi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov_cfg_seq.md
Name: ov_cfg_seq

Overview:
- Sequencer that walks a register-init table and drives the IIC master's register interface: it loads devid, addr and wdata, then pulses act_iic_write.
- It handles delays, NACK retry and per-transaction timeout.
- It sits between the system start logic / table ROM and the IIC master inside the OV interface, and brings the image sensor up after reset.

Parameters:
DEVID, 8'h42, sensor IIC write device ID driven on cfg_iic_devid
TAB_AW, 8, table address width (max 256 entries)
MAX_RETRY, 3, re-issues of one entry after NACK before error
TIMEOUT_US, 2000, us allowed per IIC transaction (busy wait) before error

Ports:
clk_sys  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pluse_us  in  1  one-cycle pulse every 1 us
start  in  1  one-cycle pulse, begin sequence from entry 0
tab_addr  out  TAB_AW  table ROM address
tab_data  in  16  ROM entry {reg_addr[15:8], reg_data[7:0]}; valid 1 cycle after tab_addr changes
cfg_iic_devid  out  8  to IIC master
cfg_iic_addr  out  8  to IIC master
cfg_iic_wdata  out  8  to IIC master
act_iic_write  out  8  bit0 = one-cycle write strobe; bits[7:1] always 0
stu_iic_status  in  8  bit0 busy, bit1 NACK (valid when busy falls)
seq_busy  out  1  sequence in progress
seq_done  out  1  sticky, table completed
seq_err  out  1  sticky, retry exhausted or timeout
err_idx  out  TAB_AW  table index of failing entry

Behaviour:
- Reset values: tab_addr=0, cfg_iic_devid=DEVID, cfg_iic_addr=0, cfg_iic_wdata=0, act_iic_write=0, seq_busy=0, seq_done=0, seq_err=0, err_idx=0.
- Entry decode:
  - 16'hFFFF: end of table.
  - {8'hFE, n}: delay n ms (n=0 means no delay).
  - Anything else: write reg_data to reg_addr.
- FSM states and transitions:
  - IDLE: on start, clear seq_done/seq_err, tab_addr=0, retry=0, seq_busy=1 -> FETCH.
  - FETCH: 1 cycle for ROM latency -> DECODE.
  - DECODE: end -> DONE. Delay -> DELAY (load ms counter). Write -> latch addr/wdata, then ISSUE.
  - ISSUE: act_iic_write=8'h01 for exactly one cycle; clear us timeout counter -> WAIT_HI.
  - WAIT_HI: busy=1 -> WAIT_LO. Timeout -> ERR.
  - WAIT_LO: on busy=0, sample NACK.
    - NACK=0: retry=0, tab_addr+1 -> FETCH.
    - NACK=1 and retry<MAX_RETRY: retry+1 -> ISSUE.
    - NACK=1 and retry=MAX_RETRY: ERR.
    - Timeout -> ERR.
  - DELAY: count ms using pluse_us (1000 pulses = 1 ms). At n ms: tab_addr+1 -> FETCH.
  - DONE: seq_done=1, seq_busy=0 -> IDLE.
  - ERR: seq_err=1, err_idx=tab_addr, seq_busy=0 -> IDLE.
- Timeout: us counter increments on pluse_us in WAIT_HI/WAIT_LO and reaches TIMEOUT_US; width = clog2(TIMEOUT_US+1).
- Latency: start to first act_iic_write strobe is exactly 4 cycles (IDLE, FETCH, DECODE, ISSUE).
- Table index wrap: tab_addr reaching 2^TAB_AW-1 without an end marker, and advancing, -> ERR with err_idx=2^TAB_AW-1. No wrap.
- start while seq_busy=1 is ignored.
- start in the same cycle a sequence ends: the end is taken and the start is ignored.
- cfg_iic_addr/wdata are held stable from ISSUE through the end of WAIT_LO.
- Reset mid-operation returns everything to reset values immediately. A transaction in flight on the IIC master is not aborted by this block.

Decomposition:
- Shared package ov_pkg: state encodings S_IDLE..S_ERR (4-bit), END_MARK=16'hFFFF, DLY_TAG=8'hFE, ACT_WRITE=8'h01, status bit indices ST_BUSY=0, ST_NACK=1.
- Sub-module ov_us_timer: a loadable us/ms down-counter driven by pluse_us with a done flag. It is shared by DELAY and the timeout check.

Test Plan:
1. Table {12 80},{11 01},FFFF with a model that raises busy for 50 us and ACKs -> two strobes with addr/wdata 0x12/0x80 then 0x11/0x01, seq_done=1, seq_err=0, first strobe 4 cycles after start.
2. Table {FE 05},{3A 04},FFFF -> write strobe no earlier than 5000 pluse_us after start, then seq_done=1.
3. Model NACKs entry 1 twice then ACKs, MAX_RETRY=3 -> 3 strobes with identical 0x11/0x01, then seq_done=1.
4. Model always NACKs entry 0 -> MAX_RETRY+1=4 strobes, seq_err=1, err_idx=0, seq_busy=0.
5. Model never raises busy -> seq_err=1 after TIMEOUT_US pulses, err_idx at the stalled entry; second start pulse during the sequence ignored.
6. Assert rst_n low during WAIT_LO -> all outputs at reset values next cycle; new start after release runs cleanly from entry 0.
